uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 149 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that feeds bytes from N_REQ requesters into one uart_tx, with per-message locking.
// Grant is combinational in IDLE (req_ready same cycle); uart_tx_start is registered and lasts 2 cycles.
module uart_tx_scheduler #(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     uart_tx_start,
  output logic [7:0]               uart_tx_data,
  input  logic                     uart_tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     active,
  output logic                     err_timeout,
  input  logic                     clear_err
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(START_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [7:0]      data_q, data_d;
  logic            last_q, last_d;
  logic            lock_q, lock_d;
  logic [GW-1:0]   lock_id_q, lock_id_d;
  logic            err_q, err_d;
  logic            start_q, start_d;

  logic [N_REQ-1:0] elig;
  logic             pick_vld;
  logic [GW-1:0]    pick_id;
  int               idx;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    elig     = lock_q ? (N_REQ'(1) << lock_id_q) : '1;
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(last_grant_q) + 1 + k) % N_REQ;
      if (!pick_vld && req_valid[idx] && elig[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    data_d       = data_q;
    last_d       = last_q;
    lock_d       = lock_q;
    lock_id_d    = lock_id_q;
    err_d        = err_q;
    req_ready    = '0;

    if (clear_err) err_d = 1'b0;

    case (state_q)
      IDLE: begin
        // No handshake while reset is held: the byte would be lost on the reset edge.
        if (pick_vld && rst_n) begin
          req_ready[pick_id] = 1'b1;
          data_d             = req_data[{pick_id, 3'b000} +: 8];
          grant_d            = pick_id;
          last_d             = req_last[pick_id];
          cnt_d              = '0;
          state_d            = LAUNCH;
          if (!req_last[pick_id]) begin
            lock_d    = 1'b1;
            lock_id_d = pick_id;
          end
        end
      end
      LAUNCH: begin
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          err_d        = 1'b1;
          lock_d       = 1'b0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          last_grant_d = grant_q;
          if (last_q) lock_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    start_d = (state_d == LAUNCH) && (cnt_d < CW'(2));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      grant_q      <= '0;
      data_q       <= 8'h00;
      last_q       <= 1'b0;
      lock_q       <= 1'b0;
      lock_id_q    <= '0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      data_q       <= data_d;
      last_q       <= last_d;
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      err_q        <= err_d;
      start_q      <= start_d;
    end
  end

  assign uart_tx_start = start_q;
  assign uart_tx_data  = data_q;
  assign grant_id      = grant_q;
  assign active        = (state_q != IDLE);
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench: requester/uart_tx models plus a launch log checked against hand-computed sequences.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy = 1'b0;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_timeout;
  logic        clear_err = 1'b0;

  uart_tx_scheduler #(.N_REQ(4), .START_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
    .grant_id(grant_id), .active(active), .err_timeout(err_timeout), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester message stores: {last, data}; main writes tail/mem, bfm advances head.
  logic [8:0] mem [4][32];
  int head [4] = '{0, 0, 0, 0};
  int tail [4] = '{0, 0, 0, 0};

  task automatic enq(input int r, input logic last, input logic [7:0] d);
    mem[r][tail[r]] = {last, d};
    tail[r]++;
  endtask

  // Launch log filled by the monitor.
  int lg_id [64];
  int lg_dat [64];
  int lg_len [64];
  int n_lg = 0;
  int n_len = 0;
  int lg_cyc = 0;
  int cyc = 0;
  int rdy_cnt [4] = '{0, 0, 0, 0};
  int bad_oh = 0;
  int bad_start = 0;
  int bad_stab = 0;
  logic busy_en = 1'b1;

  always begin : bfm
    logic pend [4];
    logic start_prev;
    int   slen;
    int   m_cnt;
    pend = '{1'b0, 1'b0, 1'b0, 1'b0};
    start_prev = 1'b0;
    slen = 0;
    m_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if ($countones(req_ready) > 1) bad_oh++;
        for (int i = 0; i < 4; i++)
          if (req_ready[i]) begin
            pend[i] = 1'b1;
            rdy_cnt[i]++;
          end
        if (uart_tx_start && !start_prev) begin
          lg_id[n_lg]  = int'(grant_id);
          lg_dat[n_lg] = int'(uart_tx_data);
          lg_cyc       = cyc;
          n_lg++;
          slen = 0;
        end
        if (uart_tx_start) slen++;
        if (!uart_tx_start && start_prev) begin
          lg_len[n_len] = slen;
          n_len++;
        end
        if (uart_tx_start && !active) bad_start++;
        if (active && n_lg > 0 &&
            (int'(uart_tx_data) != lg_dat[n_lg-1] || int'(grant_id) != lg_id[n_lg-1]))
          bad_stab++;
      end
      start_prev = uart_tx_start;

      @(posedge clk);
      #1;
      cyc++;
      // uart_tx model: busy from the 4th to the 8th cycle after start is seen.
      if (!rst_n) begin
        m_cnt = 0;
      end else if (m_cnt == 0) begin
        if (uart_tx_start) m_cnt = 1;
      end else if (m_cnt == 9) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      uart_tx_busy = busy_en && (m_cnt >= 4) && (m_cnt <= 8);

      for (int i = 0; i < 4; i++) begin
        if (pend[i]) begin
          head[i]++;
          pend[i] = 1'b0;
        end
        if (head[i] < tail[i]) begin
          req_valid[i]       = 1'b1;
          req_last[i]        = mem[i][head[i]][8];
          req_data[i*8 +: 8] = mem[i][head[i]][7:0];
        end else begin
          req_valid[i]       = 1'b0;
          req_last[i]        = 1'b0;
          req_data[i*8 +: 8] = 8'h00;
        end
      end
    end
  end

  task automatic drain(input string tag);
    int   n;
    logic busyq;
    n = 0;
    busyq = 1'b1;
    while (busyq && n < 3000) begin
      @(negedge clk);
      n++;
      busyq = active || (req_valid != 4'b0000);
      for (int i = 0; i < 4; i++)
        if (head[i] != tail[i]) busyq = 1'b1;
    end
    check_eq(tag, {31'b0, busyq}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int b, bl, r0, n;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {28'b0, req_ready}, 32'd0);
    check_eq("rst_start", {31'b0, uart_tx_start}, 32'd0);
    check_eq("rst_data", {24'b0, uart_tx_data}, 32'h00);
    check_eq("rst_grant", {30'b0, grant_id}, 32'd0);
    check_eq("rst_active", {31'b0, active}, 32'd0);
    check_eq("rst_err", {31'b0, err_timeout}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Single request
    b = n_lg; bl = n_len; r0 = rdy_cnt[0];
    enq(0, 1'b1, 8'h41);
    drain("single_drain");
    check_eq("single_n", n_lg - b, 1);
    check_eq("single_id", lg_id[b], 0);
    check_eq("single_dat", lg_dat[b], 32'h41);
    check_eq("single_len", lg_len[bl], 2);
    check_eq("single_rdy", rdy_cnt[0] - r0, 1);
    check_eq("single_err", {31'b0, err_timeout}, 32'd0);

    // Contention: two rounds of single-byte messages from a fresh reset
    do_reset();
    b = n_lg;
    for (int i = 0; i < 4; i++) begin
      enq(i, 1'b1, 8'hA0 + 8'(i));
      enq(i, 1'b1, 8'hA4 + 8'(i));
    end
    drain("cont_drain");
    check_eq("cont_n", n_lg - b, 8);
    for (int k = 0; k < 8; k++) begin
      check_eq("cont_id", lg_id[b+k], k % 4);
      check_eq("cont_dat", lg_dat[b+k], 32'hA0 + k);
    end

    // Lock: owner keeps the transmitter even while its valid is low
    b = n_lg;
    enq(0, 1'b0, 8'h10);
    enq(1, 1'b1, 8'h55);
    repeat (40) @(negedge clk);
    check_eq("lock_hold_n", n_lg - b, 1);
    check_eq("lock_hold_rdy", {28'b0, req_ready}, 32'd0);
    check_eq("lock_hold_idle", {31'b0, active}, 32'd0);
    enq(0, 1'b0, 8'h11);
    enq(0, 1'b1, 8'h12);
    drain("lock_drain");
    check_eq("lock_n", n_lg - b, 4);
    check_eq("lock_d0", lg_dat[b], 32'h10);
    check_eq("lock_d1", lg_dat[b+1], 32'h11);
    check_eq("lock_d2", lg_dat[b+2], 32'h12);
    check_eq("lock_d3", lg_dat[b+3], 32'h55);
    check_eq("lock_id3", lg_id[b+3], 1);

    // Timeout: busy never rises
    busy_en = 1'b0;
    b = n_lg; bl = n_len;
    enq(2, 1'b0, 8'h20);
    enq(2, 1'b1, 8'h21);
    enq(3, 1'b1, 8'h30);
    n = 0;
    while (!err_timeout && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("to_seen", {31'b0, err_timeout}, 32'd1);
    check_eq("to_gap", cyc - lg_cyc, 16);
    check_eq("to_idle", {31'b0, active}, 32'd0);
    @(posedge clk);
    #1 clear_err = 1'b1;
    @(posedge clk);
    #1 clear_err = 1'b0;
    @(negedge clk);
    check_eq("to_clr", {31'b0, err_timeout}, 32'd0);
    repeat (14) @(posedge clk);
    #1 clear_err = 1'b1;
    @(posedge clk);
    #1 clear_err = 1'b0;
    @(negedge clk);
    check_eq("to_set_wins", {31'b0, err_timeout}, 32'd1);
    check_eq("to_gap2", cyc - lg_cyc, 16);
    drain("to_drain");
    check_eq("to_n", n_lg - b, 3);
    check_eq("to_d0", lg_dat[b], 32'h20);
    check_eq("to_d1", lg_dat[b+1], 32'h30);
    check_eq("to_d2", lg_dat[b+2], 32'h21);
    check_eq("to_len", lg_len[bl], 2);
    busy_en = 1'b1;

    // Reset while in WAIT_DONE
    b = n_lg;
    enq(1, 1'b1, 8'h77);
    n = 0;
    while (!(active && uart_tx_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_wait", {31'b0, active && uart_tx_busy}, 32'd1);
    enq(0, 1'b1, 8'h88);
    enq(2, 1'b1, 8'h99);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("mrst_ready", {28'b0, req_ready}, 32'd0);
    check_eq("mrst_start", {31'b0, uart_tx_start}, 32'd0);
    check_eq("mrst_data", {24'b0, uart_tx_data}, 32'h00);
    check_eq("mrst_grant", {30'b0, grant_id}, 32'd0);
    check_eq("mrst_active", {31'b0, active}, 32'd0);
    check_eq("mrst_err", {31'b0, err_timeout}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drain("mrst_drain");
    check_eq("mrst_n", n_lg - b, 3);
    check_eq("mrst_d0", lg_dat[b], 32'h77);
    check_eq("mrst_id1", lg_id[b+1], 0);
    check_eq("mrst_d1", lg_dat[b+1], 32'h88);
    check_eq("mrst_id2", lg_id[b+2], 2);

    // Invariants collected over the whole run
    check_eq("inv_onehot", bad_oh, 0);
    check_eq("inv_start", bad_start, 0);
    check_eq("inv_stable", bad_stab, 0);
    for (int k = 0; k < n_len; k++) check_eq("inv_len", lg_len[k], 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
